led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
- HUB75 scan driver for the LED matrix. It consumes the frame buffer through the on-chip RAM's second port (s2), which is dual-port, has a registered address and unregistered output, and has 1-cycle read latency.
- For each scan row and each bit plane it fetches upper/lower pixel pairs and shifts them out on RGB lines.
- It then latches the row and enables the panel for a binary-weighted time (BCM).
- It sits between the frame-buffer RAM and the panel I/O pins.

Parameters:
- COLS, 48, panel columns.
- ROWS, 32, panel rows; scan is 1/(ROWS/2).
- ADDR_W, 11, RAM word address width.
- BCM_BITS, 8, colour depth per channel.
- BASE_TICKS, 4, display clocks for bit plane 0; plane b lasts BASE_TICKS<<b.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run scanning; when low, park in IDLE.
- mem_address  out  ADDR_W  RAM port-2 address; pixel (r,c) is at r*COLS+c.
- mem_chipselect  out  1  high during fetch states.
- mem_readdata  in  32  pixel word: [23:16]=R, [15:8]=G, [7:0]=B; [31:24] ignored.
- r1,g1,b1  out  1 each  upper-half pixel bit.
- r2,g2,b2  out  1 each  lower-half pixel bit.
- row_addr  out  log2(ROWS/2)  panel row select (A..D).
- mat_clk  out  1  panel shift clock.
- mat_lat  out  1  panel latch.
- mat_oe_n  out  1  panel output enable, active low.
- frame_done  out  1  one-cycle pulse after the last plane of the last row.

Behaviour:
- Reset values (asynchronous): all outputs 0 except mat_oe_n=1. Internal state: state=IDLE, row=0, plane=0, col=0.
- No write port: the RAM write interface on port 2 is tied off by the integrator.
- States: IDLE, ADDR_U, ADDR_L, CAP_L, CLK_HI, LATCH, DISPLAY.
- IDLE: mat_oe_n=1. Go to ADDR_U when enable=1.
- ADDR_U: mem_address = row*COLS+col.
- ADDR_L: mem_address = (row+ROWS/2)*COLS+col; capture upper word into reg_u.
- CAP_L: capture lower word; drive r1/g1/b1 from reg_u bit[plane] of each channel and r2/g2/b2 likewise; mat_clk=0.
- CLK_HI: mat_clk=1, data held. Then col++; if col==COLS-1, col=0 and go to LATCH, else go to ADDR_U.
- Each column takes exactly 4 cycles; a full row shift takes 4*COLS cycles.
- mat_oe_n stays 1 during all shift states (sequential scheme, no overlap with display).
- LATCH (1 cycle): mat_lat=1, row_addr<=row, mat_oe_n=1.
- DISPLAY: mat_oe_n=0 for exactly BASE_TICKS<<plane cycles; the counter width must hold BASE_TICKS<<(BCM_BITS-1). Then mat_oe_n=1 and:
  - if plane<BCM_BITS-1: plane++.
  - else plane=0 and row++.
  - if row was ROWS/2-1: row wraps to 0 and frame_done pulses on the same cycle as the exit.
  - next state: ADDR_U if enable=1, else IDLE.
- enable is sampled only in IDLE and at DISPLAY exit; a mid-row deassert completes the current plane.
- Address arithmetic is performed at ADDR_W width; (ROWS)*COLS-1 must fit, which is checked by an elaboration assertion.
- Reset mid-operation: everything returns to reset values immediately; the panel is blanked (oe_n=1) in the same cycle.
- RAM contents may change at any time; no frame-consistency guarantee.

Optional Feature:
- Macro LED_MATRIX_GAMMA_EN.
- Defined: each 8-bit channel passes through a fixed gamma-2.2 LUT, value=round(255*(x/255)^2.2), before bit-plane selection. Examples: 0->0, 128->56, 255->255. The LUT is combinational between capture and bit select, with no added latency.
- Undefined: raw channel bits are used.

Decomposition:
- Package led_matrix_pkg: state enum, channel bit-position constants (R_MSB=23, G_MSB=15, B_MSB=7), and the pixel-width constant 8.
- Sub-module led_gamma_lut: 8-bit in, 8-bit out, case ROM. It is instantiated 6 times (3 channels x 2 halves) only under LED_MATRIX_GAMMA_EN.

Test Plan:
- Reset with reset_n=0 mid-DISPLAY -> mat_oe_n=1 and all other outputs 0 in the same cycle; after release with enable=1, the first mem_address is 0, then 768.
- RAM model with 1-cycle latency; word 0=0x00FF0000 and word 768=0x000000FF, plane 0 -> first column shows r1=1,g1=0,b1=0,r2=0,g2=0,b2=1; exactly 48 mat_clk rising edges before mat_lat.
- Defaults, plane 0 then plane 7 -> mat_oe_n low for exactly 4 and then 512 consecutive cycles; row_addr changes only while mat_oe_n=1.
- Run a full frame -> frame_done pulses once, 16*8*(192+1) + 16*4*255 cycles after the first ADDR_U; row_addr sequence 0..15 then wraps to 0.
- Drop enable during the shift of row 3, plane 2 -> plane 2 completes display, then IDLE with mat_oe_n=1 and no further mat_clk edges.
- With LED_MATRIX_GAMMA_EN, pixel R=128 -> plane bits follow 56 (0b00111000), so r1=1 only on planes 3,4,5; without the macro, r1=1 only on plane 7.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the HUB75 scan driver (led_matrix_scan).
// gamma22() feeds the optional LED_MATRIX_GAMMA_EN lookup table.
package led_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_U,
        ADDR_L,
        CAP_L,
        CLK_HI,
        LATCH,
        DISPLAY
    } scan_state_t;

    localparam int unsigned R_MSB = 23;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned PIX_W = 8;

    // Elaboration-time only: round(255 * (x/255)^2.2).
    function automatic logic [7:0] gamma22(input int unsigned x);
        real v;
        v = 255.0 * ((real'(x) / 255.0) ** 2.2);
        return 8'($rtoi(v + 0.5));
    endfunction

endpackage

// File: rtl/led_gamma_lut.sv
// Gamma-2.2 ROM for one 8-bit channel; only built when LED_MATRIX_GAMMA_EN is defined.
`ifdef LED_MATRIX_GAMMA_EN
module led_gamma_lut
    import led_matrix_pkg::*;
(
    input  logic [7:0] raw,
    output logic [7:0] corrected
);

    function automatic logic [255:0][7:0] build_lut();
        logic [255:0][7:0] t;
        for (int unsigned i = 0; i < 256; i++) begin
            t[i] = gamma22(i);
        end
        return t;
    endfunction

    localparam logic [255:0][7:0] LUT = build_lut();

    always_comb begin
        corrected = LUT[raw];
    end

endmodule
`endif

// File: rtl/led_matrix_scan.sv
// HUB75 scan driver: fetches upper/lower pixel pairs, shifts one bit plane per row, then BCM display.
// Optional LED_MATRIX_GAMMA_EN routes every channel through led_gamma_lut before plane selection.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int unsigned COLS       = 48,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned BCM_BITS   = 8,
    parameter int unsigned BASE_TICKS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    output logic [ADDR_W-1:0]            mem_address,
    output logic                         mem_chipselect,
    input  logic [31:0]                  mem_readdata,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         r2,
    output logic                         g2,
    output logic                         b2,
    output logic [$clog2(ROWS/2)-1:0]    row_addr,
    output logic                         mat_clk,
    output logic                         mat_lat,
    output logic                         mat_oe_n,
    output logic                         frame_done
);

    localparam int unsigned HALF   = ROWS / 2;
    localparam int unsigned ROW_W  = $clog2(HALF);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned PL_W   = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
    localparam int unsigned TICK_W = $clog2((BASE_TICKS << (BCM_BITS - 1)) + 1);

    if (ROWS * COLS > (1 << ADDR_W)) begin : g_addr_check
        $error("led_matrix_scan: ROWS*COLS-1 does not fit in ADDR_W bits");
    end

    scan_state_t         state, state_nxt;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [PL_W-1:0]     plane;
    logic [TICK_W-1:0]   tick;
    logic [23:0]         reg_u;
    logic [ADDR_W-1:0]   addr_u, addr_l;
    logic [TICK_W-1:0]   disp_last;
    logic                last_col, tick_done;
    logic                unused_hi;

    logic [PIX_W-1:0] up_r_raw, up_g_raw, up_b_raw, lo_r_raw, lo_g_raw, lo_b_raw;
    logic [PIX_W-1:0] up_r, up_g, up_b, lo_r, lo_g, lo_b;

    assign unused_hi = ^mem_readdata[31:24];

    assign addr_u    = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    assign addr_l    = (ADDR_W'(row) + ADDR_W'(HALF)) * ADDR_W'(COLS) + ADDR_W'(col);
    assign last_col  = (col == COL_W'(COLS - 1));
    assign disp_last = (TICK_W'(BASE_TICKS) << plane) - TICK_W'(1);
    assign tick_done = (tick == disp_last);

    // Upper word comes from the register captured in ADDR_L; lower word is live during CAP_L.
    assign up_r_raw = reg_u[R_MSB -: PIX_W];
    assign up_g_raw = reg_u[G_MSB -: PIX_W];
    assign up_b_raw = reg_u[B_MSB -: PIX_W];
    assign lo_r_raw = mem_readdata[R_MSB -: PIX_W];
    assign lo_g_raw = mem_readdata[G_MSB -: PIX_W];
    assign lo_b_raw = mem_readdata[B_MSB -: PIX_W];

`ifdef LED_MATRIX_GAMMA_EN
    led_gamma_lut u_gamma_ur (.raw(up_r_raw), .corrected(up_r));
    led_gamma_lut u_gamma_ug (.raw(up_g_raw), .corrected(up_g));
    led_gamma_lut u_gamma_ub (.raw(up_b_raw), .corrected(up_b));
    led_gamma_lut u_gamma_lr (.raw(lo_r_raw), .corrected(lo_r));
    led_gamma_lut u_gamma_lg (.raw(lo_g_raw), .corrected(lo_g));
    led_gamma_lut u_gamma_lb (.raw(lo_b_raw), .corrected(lo_b));
`else
    assign up_r = up_r_raw;
    assign up_g = up_g_raw;
    assign up_b = up_b_raw;
    assign lo_r = lo_r_raw;
    assign lo_g = lo_g_raw;
    assign lo_b = lo_b_raw;
`endif

    always_comb begin
        state_nxt      = state;
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mat_clk        = 1'b0;
        mat_lat        = 1'b0;
        mat_oe_n       = 1'b1;
        unique case (state)
            IDLE:    if (enable) state_nxt = ADDR_U;
            ADDR_U:  begin
                mem_chipselect = 1'b1;
                mem_address    = addr_u;
                state_nxt      = ADDR_L;
            end
            ADDR_L:  begin
                mem_chipselect = 1'b1;
                mem_address    = addr_l;
                state_nxt      = CAP_L;
            end
            CAP_L:   begin
                mem_chipselect = 1'b1;
                state_nxt      = CLK_HI;
            end
            CLK_HI:  begin
                mat_clk   = 1'b1;
                state_nxt = last_col ? LATCH : ADDR_U;
            end
            LATCH:   begin
                mat_lat   = 1'b1;
                state_nxt = DISPLAY;
            end
            DISPLAY: begin
                mat_oe_n = 1'b0;
                if (tick_done) state_nxt = enable ? ADDR_U : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            plane      <= '0;
            tick       <= '0;
            reg_u      <= '0;
            r1         <= 1'b0;
            g1         <= 1'b0;
            b1         <= 1'b0;
            r2         <= 1'b0;
            g2         <= 1'b0;
            b2         <= 1'b0;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            unique case (state)
                ADDR_L: reg_u <= mem_readdata[23:0];
                CAP_L: begin
                    r1 <= up_r[plane];
                    g1 <= up_g[plane];
                    b1 <= up_b[plane];
                    r2 <= lo_r[plane];
                    g2 <= lo_g[plane];
                    b2 <= lo_b[plane];
                end
                CLK_HI: begin
                    // row_addr is updated on entry to LATCH so it never moves while the panel is lit.
                    if (last_col) begin
                        col      <= '0;
                        row_addr <= row;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                LATCH: tick <= '0;
                DISPLAY: begin
                    if (tick_done) begin
                        if (plane == PL_W'(BCM_BITS - 1)) begin
                            plane <= '0;
                            if (row == ROW_W'(HALF - 1)) begin
                                row        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            plane <= plane + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: frame-schedule model plus directed literal checks.
module tb_led_matrix_scan;

    localparam int COLS  = 48;
    localparam int ROWS  = 32;
    localparam int HALF  = 16;
    localparam int BCM   = 8;
    localparam int BASE  = 4;
    localparam int SHIFT = 4 * COLS;
    localparam int FRAME = 41024;   // 16*(8*193 + 4*255)

`ifdef LED_MATRIX_GAMMA_EN
    localparam logic [7:0] R128_MASK = 8'h38;
`else
    localparam logic [7:0] R128_MASK = 8'h80;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] mem_address;
    logic        mem_chipselect;
    logic [31:0] mem_readdata;
    logic        r1, g1, b1, r2, g2, b2;
    logic [3:0]  row_addr;
    logic        mat_clk, mat_lat, mat_oe_n, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .BCM_BITS(BCM), .BASE_TICKS(BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_readdata(mem_readdata),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .row_addr(row_addr), .mat_clk(mat_clk), .mat_lat(mat_lat),
        .mat_oe_n(mat_oe_n), .frame_done(frame_done)
    );

    // RAM port 2: registered address, unregistered output.
    logic [31:0] mem [0:2047];
    logic [10:0] ram_q = '0;
    always @(posedge clk) ram_q <= mem_address;
    assign mem_readdata = mem[ram_q];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan(input int v);
`ifdef LED_MATRIX_GAMMA_EN
        return $rtoi(255.0 * ((real'(v) / 255.0) ** 2.2) + 0.5);
`else
        return v;
`endif
    endfunction

    function automatic logic bitof(input logic [7:0] v, input int p);
        int c;
        c = chan(int'(v));
        return c[p];
    endfunction

    function automatic logic [5:0] pix_bits(input int row, input int col, input int plane);
        logic [31:0] u, l;
        u = mem[row * COLS + col];
        l = mem[(row + HALF) * COLS + col];
        return {bitof(u[23:16], plane), bitof(u[15:8], plane), bitof(u[7:0], plane),
                bitof(l[23:16], plane), bitof(l[15:8], plane), bitof(l[7:0], plane)};
    endfunction

    // Model: position inside a plane segment of SHIFT + 1 + (BASE<<plane) cycles.
    int   m_run = 0, m_row = 0, m_plane = 0, m_off = 0, m_ra = 0;
    logic m_fd = 1'b0;
    logic [3:0] prev_ra = '0;
    logic prev_oe = 1'b1, prev_rst = 1'b0;

    always @(negedge clk) begin : model
        int col, ph;
        logic e_cs, e_clk, e_lat, e_oe;
        logic [8:0] act_ctrl, exp_ctrl;
        if (!reset_n) begin
            m_run = 0; m_row = 0; m_plane = 0; m_off = 0; m_ra = 0; m_fd = 1'b0;
            chk("reset_outs", {mem_address, mem_chipselect, r1, g1, b1, r2, g2, b2,
                               row_addr, mat_clk, mat_lat, mat_oe_n, frame_done}, 26'h2);
        end else begin
            e_cs = 1'b0; e_clk = 1'b0; e_lat = 1'b0; e_oe = 1'b1;
            if (m_run != 0) begin
                if (m_off < SHIFT) begin
                    col   = m_off / 4;
                    ph    = m_off % 4;
                    e_cs  = (ph != 3);
                    e_clk = (ph == 3);
                    if (ph == 0) chk("addr_upper", mem_address, m_row * COLS + col);
                    if (ph == 1) chk("addr_lower", mem_address, (m_row + HALF) * COLS + col);
                    if (ph == 3) chk("pixel_bits", {r1, g1, b1, r2, g2, b2}, pix_bits(m_row, col, m_plane));
                end else if (m_off == SHIFT) begin
                    e_lat = 1'b1;
                    m_ra  = m_row;
                end else begin
                    e_oe = 1'b0;
                end
            end
            act_ctrl = {mem_chipselect, mat_clk, mat_lat, mat_oe_n, frame_done, row_addr};
            exp_ctrl = {e_cs, e_clk, e_lat, e_oe, m_fd, 4'(m_ra)};
            chk("ctrl", act_ctrl, exp_ctrl);
            if (prev_rst && row_addr != prev_ra)
                chk("row_addr_change_blanked", {prev_oe, mat_oe_n}, 2'b11);
            m_fd = 1'b0;
            if (m_run == 0) begin
                if (enable) begin m_run = 1; m_off = 0; end
            end else begin
                m_off++;
                if (m_off == SHIFT + 1 + (BASE << m_plane)) begin
                    m_off = 0;
                    if (m_plane == BCM - 1) begin
                        m_plane = 0;
                        if (m_row == HALF - 1) begin m_row = 0; m_fd = 1'b1; end
                        else m_row++;
                    end else begin
                        m_plane++;
                    end
                    if (!enable) m_run = 0;
                end
            end
        end
        prev_ra  = row_addr;
        prev_oe  = mat_oe_n;
        prev_rst = reset_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int k, t, fd_cnt, fd_at, lat_cnt, clk_cnt, run, seen, idle_clk, idle_act;
        logic [7:0] r1_mask;

        for (int i = 0; i < 2048; i++) mem[i] = 32'h9E3779B9 * 32'(i + 1);
        mem[0]   = 32'h00FF0000;
        mem[1]   = 32'h00800000;
        mem[768] = 32'h000000FF;

        repeat (3) @(negedge clk);
        chk("rst_oe_n", mat_oe_n, 1);
        chk("rst_outs", {mem_address, mem_chipselect, r1, g1, b1, r2, g2, b2,
                         row_addr, mat_clk, mat_lat, frame_done}, 0);

        // Reset asserted in the middle of a display window.
        @(posedge clk); #1 reset_n = 1'b1; enable = 1'b1;
        k = 0;
        @(negedge clk);
        while (mat_oe_n && k < 2000) begin @(negedge clk); k++; end
        chk("reach_display", mat_oe_n, 0);
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_oe_n", mat_oe_n, 1);
        chk("rst_mid_outs", {mem_address, mem_chipselect, r1, g1, b1, r2, g2, b2,
                             row_addr, mat_clk, mat_lat, frame_done}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        k = 0;
        @(negedge clk);
        while (!mem_chipselect && k < 20) begin @(negedge clk); k++; end
        chk("first_cs", mem_chipselect, 1);
        chk("first_addr", mem_address, 0);

        // Full frame from the first ADDR_U (t = 0).
        t = 0; fd_cnt = 0; fd_at = -1; lat_cnt = 0; clk_cnt = 0; run = 0; r1_mask = '0;
        while (t < FRAME + 200) begin
            if (t == 1) chk("second_addr", mem_address, 768);
            if (t == 3) chk("col0_plane0", {mat_clk, r1, g1, b1, r2, g2, b2}, 7'b1100001);
            if (mat_clk) begin
                clk_cnt++;
                if (clk_cnt == 2 && lat_cnt < 8) r1_mask[lat_cnt] = r1;
            end
            if (mat_lat) begin
                if (lat_cnt == 0) chk("clk_edges_before_lat", clk_cnt, 48);
                chk("row_addr_at_lat", row_addr, (lat_cnt / 8) % 16);
                lat_cnt++;
                clk_cnt = 0;
            end
            if (!mat_oe_n) begin
                run++;
            end else if (run != 0) begin
                if (lat_cnt == 1) chk("oe_run_plane0", run, 4);
                if (lat_cnt == 8) chk("oe_run_plane7", run, 512);
                if (lat_cnt >= 1 && lat_cnt <= 8) chk("oe_run_row0", run, 4 << (lat_cnt - 1));
                run = 0;
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd_at = t;
            end
            @(negedge clk);
            t++;
        end
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_done_cycle", fd_at, FRAME);
        chk("latch_count", lat_cnt, 129);
        chk("r1_r128_plane_mask", r1_mask, R128_MASK);

        // Drop enable during the shift of row 3, plane 2.
        k = 0; seen = 0;
        while (k < 20000 && seen < 2) begin
            @(negedge clk); k++;
            if (mat_lat && row_addr == 4'd3) seen++;
        end
        chk("row3_plane1_latch", seen, 2);
        while (mat_oe_n && k < 20000) begin @(negedge clk); k++; end
        while (!mat_oe_n && k < 20000) begin @(negedge clk); k++; end
        chk("row3_plane2_shift", mat_oe_n, 1);
        repeat (20) @(negedge clk);
        @(posedge clk); #1 enable = 1'b0;

        k = 0;
        @(negedge clk);
        while (!mat_lat && k < 400) begin @(negedge clk); k++; end
        chk("drop_latch_seen", mat_lat, 1);
        chk("drop_row_addr", row_addr, 3);
        run = 0;
        @(negedge clk);
        while (!mat_oe_n && run < 2000) begin run++; @(negedge clk); end
        chk("drop_plane2_run", run, 16);
        idle_clk = 0; idle_act = 0;
        repeat (300) begin
            if (mat_clk) idle_clk++;
            if (!mat_oe_n || mem_chipselect) idle_act++;
            @(negedge clk);
        end
        chk("idle_no_mat_clk", idle_clk, 0);
        chk("idle_blanked", idle_act, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
